// File: rtl/fazyrv_alu_seq_pkg.sv
// Shared types for the chunked ALU sequencer: opcodes, ALU control bundle,
// sequencer states and the opcode decoder.
package fazyrv_alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_PASS = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_LT   = 4'd3,
    OP_LTU  = 4'd4,
    OP_EQ   = 4'd5,
    OP_XOR  = 4'd6,
    OP_OR   = 4'd7,
    OP_AND  = 4'd8
  } alu_op_e;

  typedef struct packed {
    logic sel_arith;
    logic en_a;
    logic op_sub;
    logic op_xor;
    logic op_and;
    logic cmp_signd;
    logic cmp_eq;
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Unassigned codes fall through to PASS.
  function automatic alu_ctrl_t alu_decode(alu_op_e op);
    alu_ctrl_t c;
    c = '0;
    case (op)
      OP_ADD: begin c.sel_arith = 1'b1; c.en_a = 1'b1; end
      OP_SUB: begin c.sel_arith = 1'b1; c.en_a = 1'b1; c.op_sub = 1'b1; end
      OP_LT:  begin c.en_a = 1'b1; c.cmp_signd = 1'b1; end
      OP_LTU: c.en_a = 1'b1;
      OP_EQ:  begin c.en_a = 1'b1; c.cmp_eq = 1'b1; end
      OP_XOR: begin c.en_a = 1'b1; c.op_xor = 1'b1; end
      OP_OR:  c.en_a = 1'b1;
      OP_AND: begin c.en_a = 1'b1; c.op_and = 1'b1; end
      default: c.sel_arith = 1'b1;
    endcase
    return c;
  endfunction

  function automatic logic is_cmp_op(alu_op_e op);
    return (op == OP_LT) || (op == OP_LTU) || (op == OP_EQ);
  endfunction

endpackage

// File: rtl/fazyrv_alu_seq_if.sv
// Request/response bus of the ALU sequencer; master is the requester,
// slave is the sequencer.
interface fazyrv_alu_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_res;
  logic        rsp_cmp;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_res, rsp_cmp
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_res, rsp_cmp
  );
endinterface

// File: rtl/fazyrv_alu.sv
// Chunked ALU slice: processes CHUNKSIZE bits per cycle LSB-first, carrying
// adder, compare-borrow and equality state between chunks.
module fazyrv_alu #(
  parameter int CHUNKSIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 lsb_i,
  input  logic                 msb_i,
  input  logic [CHUNKSIZE-1:0] a_i,
  input  logic [CHUNKSIZE-1:0] b_i,
  input  logic                 sel_arith_i,
  input  logic                 en_a_i,
  input  logic                 op_sub_i,
  input  logic                 op_xor_i,
  input  logic                 op_and_i,
  input  logic                 cmp_signd_i,
  input  logic                 cmp_eq_i,
  input  logic                 cmp_keep_i,
  output logic [CHUNKSIZE-1:0] res_o,
  output logic                 cmp_o
);

  logic [CHUNKSIZE-1:0] a_eff;
  logic [CHUNKSIZE:0]   add_sum;
  logic [CHUNKSIZE:0]   diff;
  logic                 add_c_r, cmp_c_r, eq_r;
  logic                 add_cin, cmp_cin, eq_in, eq_now;
  logic                 ltu, lt;

  assign a_eff   = en_a_i ? a_i : '0;
  assign add_cin = lsb_i ? op_sub_i : add_c_r;
  assign add_sum = {1'b0, a_eff} + {1'b0, b_i ^ {CHUNKSIZE{op_sub_i}}}
                 + {{CHUNKSIZE{1'b0}}, add_cin};

  // Independent borrow chain so compares are available for every opcode.
  assign cmp_cin = lsb_i ? 1'b1 : cmp_c_r;
  assign diff    = {1'b0, a_eff} + {1'b0, ~b_i} + {{CHUNKSIZE{1'b0}}, cmp_cin};
  assign eq_in   = (lsb_i && !cmp_keep_i) ? 1'b1 : eq_r;
  assign eq_now  = eq_in && (a_eff == b_i);

  assign ltu = ~diff[CHUNKSIZE];
  assign lt  = (a_eff[CHUNKSIZE-1] ^ b_i[CHUNKSIZE-1]) ? a_eff[CHUNKSIZE-1]
                                                       : diff[CHUNKSIZE-1];

  always_comb begin
    res_o = a_eff | b_i;
    if (sel_arith_i)   res_o = add_sum[CHUNKSIZE-1:0];
    else if (op_xor_i) res_o = a_eff ^ b_i;
    else if (op_and_i) res_o = a_eff & b_i;
  end

  assign cmp_o = msb_i && (cmp_eq_i ? eq_now : (cmp_signd_i ? lt : ltu));

  always_ff @(posedge clk_i) begin
    add_c_r <= add_sum[CHUNKSIZE];
    cmp_c_r <= diff[CHUNKSIZE];
    eq_r    <= eq_now;
  end

endmodule

// File: rtl/fazyrv_alu_seq.sv
// 32-bit valid/ready ALU built by streaming operands through fazyrv_alu.
// FAZYRV_ALU_SEQ_B2B_EN: accept a new request in the same cycle a response is taken.
module fazyrv_alu_seq
  import fazyrv_alu_seq_pkg::*;
#(
  parameter int CHUNKSIZE = 8
) (
  input logic              clk_i,
  input logic              rst_i,
  fazyrv_alu_seq_if.slave  bus
);

  localparam int ITERATIONS = 32 / CHUNKSIZE;
  localparam int CNT_W      = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERATIONS - 1);

  state_e               state, state_nxt;
  logic [31:0]          a_r, b_r, res_r;
  alu_op_e              op_r;
  logic                 cmp_r;
  logic [CNT_W-1:0]     cnt;
  logic                 req_ready, accept, lsb, msb;
  alu_ctrl_t            ctrl;
  logic [CHUNKSIZE-1:0] alu_res;
  logic                 alu_cmp;

  assign lsb    = (state == RUN) && (cnt == '0);
  assign msb    = (state == RUN) && (cnt == CNT_LAST);
  assign accept = bus.req_valid && req_ready;
  assign ctrl   = alu_decode(op_r);

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) state_nxt = RUN;
      end
      RUN: begin
        if (msb) state_nxt = DONE;
      end
      DONE: begin
`ifdef FAZYRV_ALU_SEQ_B2B_EN
        req_ready = bus.rsp_ready;
        if (bus.rsp_ready) state_nxt = bus.req_valid ? RUN : IDLE;
`else
        if (bus.rsp_ready) state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_r   <= '0;
      b_r   <= '0;
      res_r <= '0;
      op_r  <= OP_PASS;
      cmp_r <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      a_r  <= bus.req_a;
      b_r  <= bus.req_b;
      op_r <= alu_op_e'(bus.req_op);
      cnt  <= '0;
    end else if (state == RUN) begin
      a_r   <= a_r >> CHUNKSIZE;
      b_r   <= b_r >> CHUNKSIZE;
      // Result chunks enter at the top so the LSB chunk ends up at bit 0.
      res_r <= (res_r >> CHUNKSIZE) | (32'(alu_res) << (32 - CHUNKSIZE));
      cnt   <= cnt + CNT_W'(1);
      if (msb) cmp_r <= alu_cmp;
    end
  end

  fazyrv_alu #(.CHUNKSIZE(CHUNKSIZE)) u_alu (
    .clk_i       (clk_i),
    .lsb_i       (lsb),
    .msb_i       (msb),
    .a_i         (a_r[CHUNKSIZE-1:0]),
    .b_i         (b_r[CHUNKSIZE-1:0]),
    .sel_arith_i (ctrl.sel_arith),
    .en_a_i      (ctrl.en_a),
    .op_sub_i    (ctrl.op_sub),
    .op_xor_i    (ctrl.op_xor),
    .op_and_i    (ctrl.op_and),
    .cmp_signd_i (ctrl.cmp_signd),
    .cmp_eq_i    (ctrl.cmp_eq),
    .cmp_keep_i  (1'b0),
    .res_o       (alu_res),
    .cmp_o       (alu_cmp)
  );

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_res   = is_cmp_op(op_r) ? {31'b0, cmp_r} : res_r;
  assign bus.rsp_cmp   = cmp_r;

endmodule

// File: tb/tb_fazyrv_alu_seq.sv
// Bench for fazyrv_alu_seq: three instances (CHUNKSIZE 8, 32, 1) against a
// word-level reference model.
module tb_fazyrv_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid[3];
  logic        req_ready[3];
  logic [3:0]  req_op[3];
  logic [31:0] req_a[3];
  logic [31:0] req_b[3];
  logic        rsp_valid[3];
  logic        rsp_ready[3];
  logic [31:0] rsp_res[3];
  logic        rsp_cmp[3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  genvar g;
  for (g = 0; g < 3; g++) begin : g_dut
    localparam int CS = (g == 0) ? 8 : ((g == 1) ? 32 : 1);
    fazyrv_alu_seq_if bus ();
    assign bus.req_valid = req_valid[g];
    assign bus.req_op    = req_op[g];
    assign bus.req_a     = req_a[g];
    assign bus.req_b     = req_b[g];
    assign bus.rsp_ready = rsp_ready[g];
    assign req_ready[g]  = bus.req_ready;
    assign rsp_valid[g]  = bus.rsp_valid;
    assign rsp_res[g]    = bus.rsp_res;
    assign rsp_cmp[g]    = bus.rsp_cmp;
    fazyrv_alu_seq #(.CHUNKSIZE(CS)) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int iters_of(int k);
    return (k == 0) ? 4 : ((k == 1) ? 1 : 32);
  endfunction

  function automatic logic [1:0] probe_mark(int k);
    case (k)
      0:       return {g_dut[0].u_dut.lsb, g_dut[0].u_dut.msb};
      1:       return {g_dut[1].u_dut.lsb, g_dut[1].u_dut.msb};
      default: return {g_dut[2].u_dut.lsb, g_dut[2].u_dut.msb};
    endcase
  endfunction

  // Word-level reference: returns {cmp, res}.
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] ae, res;
    logic        cmp;
    ae  = (op >= 4'd1 && op <= 4'd8) ? a : 32'd0;
    cmp = (op == 4'd5) ? (ae == b) :
          (op == 4'd3) ? ($signed(ae) < $signed(b)) : (ae < b);
    case (op)
      4'd1:                res = a + b;
      4'd2:                res = a - b;
      4'd3, 4'd4, 4'd5:    res = {31'd0, cmp};
      4'd6:                res = a ^ b;
      4'd7:                res = a | b;
      4'd8:                res = a & b;
      default:             res = b;
    endcase
    return {cmp, res};
  endfunction

  task automatic do_op(input int k, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    int n;
    int it;
    logic [32:0] exp;
    it  = iters_of(k);
    exp = model(op, a, b);
    req_op[k] = op; req_a[k] = a; req_b[k] = b; req_valid[k] = 1'b1;
    n = 0;
    while (!req_ready[k] && n < 50) begin @(posedge clk); #1; n++; end
    check("req_ready_wait", 64'(req_ready[k]), 64'd1);
    @(posedge clk); #1;
    req_valid[k] = 1'b0; req_a[k] = $urandom; req_b[k] = $urandom; req_op[k] = 4'($urandom);
    n = 0;
    while (!rsp_valid[k] && n < 100) begin
      check("lsb_msb", 64'(probe_mark(k)), 64'({n == 0, n == it - 1}));
      check("run_req_ready", 64'(req_ready[k]), 64'd0);
      @(posedge clk); #1; n++;
    end
    check("latency", 64'(n), 64'(it));
    check("rsp_res", 64'(rsp_res[k]), 64'(exp[31:0]));
    check("rsp_cmp", 64'(rsp_cmp[k]), 64'(exp[32]));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(rsp_valid[k]), 64'd1);
      check("hold_res", 64'(rsp_res[k]), 64'(exp[31:0]));
      check("hold_cmp", 64'(rsp_cmp[k]), 64'(exp[32]));
      check("hold_req_ready", 64'(req_ready[k]), 64'd0);
    end
    rsp_ready[k] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[k] = 1'b0;
    check("rsp_drop", 64'(rsp_valid[k]), 64'd0);
  endtask

  task automatic do_stream(input int k);
    logic [32:0] q[$];
    logic [31:0] ca, cb;
    logic [32:0] exp;
    logic        fire_req, fire_rsp;
    int cyc, last, got, sent, gap;
`ifdef FAZYRV_ALU_SEQ_B2B_EN
    gap = iters_of(k) + 1;
`else
    gap = iters_of(k) + 2;
`endif
    cyc = 0; last = -1; got = 0; sent = 0;
    ca = $urandom; cb = $urandom;
    rsp_ready[k] = 1'b1;
    req_op[k] = 4'd1; req_a[k] = ca; req_b[k] = cb; req_valid[k] = 1'b1;
    while (got < 4 && cyc < 300) begin
      fire_req = req_valid[k] && req_ready[k];
      fire_rsp = rsp_valid[k] && rsp_ready[k];
      if (fire_rsp) begin
        if (q.size() == 0) check("stream_unexpected", 64'd1, 64'd0);
        else begin
          exp = q.pop_front();
          check("stream_res", 64'(rsp_res[k]), 64'(exp[31:0]));
        end
        if (last >= 0) check("stream_gap", 64'(cyc - last), 64'(gap));
        last = cyc;
        got++;
      end
      @(posedge clk); #1; cyc++;
      if (fire_req) begin
        q.push_back(model(4'd1, ca, cb));
        sent++;
        if (sent < 4) begin
          ca = $urandom; cb = $urandom;
          req_a[k] = ca; req_b[k] = cb;
        end else req_valid[k] = 1'b0;
      end
    end
    check("stream_count", 64'(got), 64'd4);
    rsp_ready[k] = 1'b0;
    req_valid[k] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, b;
    logic [3:0]  op;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; rsp_ready[k] = 1'b0;
      req_op[k] = 4'd0; req_a[k] = '0; req_b[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < 3; k++) begin
      check("rst_rsp_valid", 64'(rsp_valid[k]), 64'd0);
      check("rst_req_ready", 64'(req_ready[k]), 64'd1);
      check("rst_rsp_res", 64'(rsp_res[k]), 64'd0);
      check("rst_rsp_cmp", 64'(rsp_cmp[k]), 64'd0);
    end

    do_op(0, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    do_op(0, 4'd2, 32'h0000_0000, 32'h0000_0001, 0);
    do_op(0, 4'd8, 32'hF0F0_F0F0, 32'hFF00_FF00, 1);
    do_op(0, 4'd3, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    do_op(0, 4'd4, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    do_op(0, 4'd5, 32'h1234_5678, 32'h1234_5678, 0);
    do_op(0, 4'd6, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 10);
    do_op(0, 4'd0, 32'h1111_1111, 32'h8000_0000, 0);
    do_op(0, 4'd12, 32'h1111_1111, 32'h0000_0000, 0);

    // Abort an ADD in its second RUN cycle.
    req_op[0] = 4'd1; req_a[0] = 32'd100; req_b[0] = 32'd200; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    check("abort_req_ready", 64'(req_ready[0]), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort_quiet", 64'(rsp_valid[0]), 64'd0);
    end
    do_op(0, 4'd1, 32'd3, 32'd4, 0);

    for (int k = 0; k < 3; k++) begin
      do_op(k, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 0);
      do_op(k, 4'd3, 32'h8000_0000, 32'h7FFF_FFFF, 0);
      for (int n = 0; n < 25; n++) begin
        op = 4'($urandom);
        b  = $urandom;
        case ($urandom_range(0, 4))
          0: a = b;
          1: a = 32'h0;
          2: a = 32'hFFFF_FFFF;
          3: a = 32'h8000_0000;
          default: a = $urandom;
        endcase
        do_op(k, op, a, b, $urandom_range(0, 3));
      end
      do_stream(k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fazyrv_alu_seq.md
Name: fazyrv_alu_seq

Overview:
Sequencer wrapping one chunked `fazyrv_alu` instance so it behaves as a 32-bit ALU with a valid/ready request and response interface. It latches a full 32-bit operand pair and opcode, then streams CHUNKSIZE-bit slices LSB-first through the ALU. It generates the lsb/msb chunk markers and decodes the opcode into ALU control signals. It reassembles the 32-bit result and the compare flag. It sits between the core's execute control and the bit-serial/chunked ALU datapath.

Parameters:
- CHUNKSIZE, 8, ALU slice width; legal values 1, 2, 4, 8, 16, 32.
- ITERATIONS, 32/CHUNKSIZE, derived; number of chunk cycles per operation.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_op_i  in  4  opcode, alu_op_e encoding
- req_a_i  in  32  operand A
- req_b_i  in  32  operand B
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_res_o  out  32  result word
- rsp_cmp_o  out  1  compare flag

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high.
- Opcode encoding (alu_op_e):
  - PASS=0, ADD=1, SUB=2, LT=3, LTU=4, EQ=5, XOR=6, OR=7, AND=8.
  - Codes 9..15 decode as PASS.
- Decode per op (all other controls 0):
  - PASS: sel_arith.
  - ADD: sel_arith, en_a.
  - SUB: sel_arith, en_a, op_sub.
  - LT: en_a, cmp_signd.
  - LTU: en_a.
  - EQ: en_a, cmp_eq.
  - XOR: en_a, op_xor.
  - OR: en_a.
  - AND: en_a, op_and.
  - cmp_keep_i is tied 0.
- FSM states: IDLE, RUN, DONE.
  - Reset: state=IDLE, chunk counter=0, rsp_valid_o=0, req_ready_o=1, rsp_res_o=0, rsp_cmp_o=0.
  - IDLE: req_ready_o=1. On req_valid_i, latch a, b and op into shift registers and go to RUN with cnt=0.
  - RUN: req_ready_o=0. Each cycle feeds a_r[CHUNKSIZE-1:0] and b_r[CHUNKSIZE-1:0] to the ALU.
    - lsb_i=1 iff cnt==0; msb_i=1 iff cnt==ITERATIONS-1. Both are 1 in the same cycle when ITERATIONS==1.
    - Every cycle, a_r and b_r shift right by CHUNKSIZE, and res_o is shifted into the top of res_r.
    - cnt increments by 1.
    - On the msb cycle, latch cmp_o into cmp_r and go to DONE.
  - DONE: rsp_valid_o=1. Outputs are held stable until rsp_ready_i; then go to IDLE (see optional feature).
- Result selection:
  - LT/LTU/EQ: rsp_res_o = {31'b0, cmp_r}.
  - All other ops: rsp_res_o = res_r.
  - rsp_cmp_o = cmp_r for every op.
- Latency: request accepted at cycle t → rsp_valid_o high at t+ITERATIONS+1 (t+5 for CHUNKSIZE=8).
- Backpressure: response is held indefinitely with no data change; no new request is accepted while in RUN or DONE (except the optional-feature case).
- Wrap: the counter width is $clog2(ITERATIONS), minimum 1 bit; it resets to 0 on every accept.
- Reset mid-operation: aborts immediately to IDLE, drops rsp_valid_o, discards partial result; the ALU carry state is reinitialised by the next lsb.
- Requests presented while not ready are ignored; the requester must hold them stable.

Optional Feature:
- Macro: FAZYRV_ALU_SEQ_B2B_EN.
- Defined:
  - In DONE, req_ready_o = rsp_ready_i.
  - A simultaneous response handshake and request handshake loads the new operands and enters RUN directly, skipping IDLE.
  - Sustained throughput: one op per ITERATIONS+1 cycles.
- Undefined:
  - req_ready_o is high only in IDLE.
  - One idle bubble per op; throughput is one op per ITERATIONS+2 cycles.

Decomposition:
- Package fazyrv_alu_seq_pkg holds:
  - alu_op_e enum;
  - alu_ctrl_t struct (sel_arith, en_a, op_sub, op_xor, op_and, cmp_signd, cmp_eq);
  - decode function op→alu_ctrl_t;
  - state enum.
- The only sub-module is the existing fazyrv_alu instance; no further sub-module is warranted.

Test Plan (CHUNKSIZE=8 unless stated):
- ADD a=0xFFFFFFFF, b=0x00000001, accepted at t → rsp_valid_o rises at t+5, rsp_res_o=0x00000000; lsb_i pulses at t+1, msb_i at t+4.
- SUB a=0x00000000, b=0x00000001 → rsp_res_o=0xFFFFFFFF. Then AND a=0xF0F0F0F0, b=0xFF00FF00 → rsp_res_o=0xF000F000.
- LT a=0xFFFFFFFF, b=0x00000001 → rsp_cmp_o=1, rsp_res_o=1. LTU with the same operands → rsp_cmp_o=0, rsp_res_o=0. EQ a=b=0x12345678 → rsp_cmp_o=1.
- Backpressure: rsp_ready_i=0 for 10 cycles after XOR a=0xAAAAAAAA, b=0xFFFFFFFF → rsp_res_o=0x55555555 held stable; req_ready_o=0 throughout.
- Reset asserted at the 2nd RUN cycle of an ADD → next cycle IDLE, rsp_valid_o=0, req_ready_o=1. A following ADD 3+4 returns 7.
- Back-to-back stream of 4 ADDs with rsp_ready_i=1:
  - with FAZYRV_ALU_SEQ_B2B_EN defined, responses arrive 5 cycles apart;
  - without it, 6 cycles apart;
  - repeat with CHUNKSIZE=32 (lsb_i and msb_i are high together) and CHUNKSIZE=1.
